// File: rtl/ad7960_capture.sv
// ad7960_capture: CNV timing, SCK generation and serial capture for the AD7960.
// Samples leave on a valid/ready port; overrun and missed-trigger are sticky.
module ad7960_capture #(
    parameter int DATA_WIDTH   = 18,
    parameter int CNV_PULSE    = 4,
    parameter int CONV_WAIT    = 30,
    parameter int SCK_HALF     = 1,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    clear_status,
    output logic                    adc_cnv,
    output logic                    adc_sck,
    input  logic                    adc_dout,
    output logic [DATA_WIDTH-1:0]   m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy,
    output logic                    overrun,
    output logic                    missed_trigger
);
    localparam int LAT = CNV_PULSE + CONV_WAIT + 2 * SCK_HALF * DATA_WIDTH + 1;
    localparam int MIN_PERIOD = LAT + 1;
    localparam int TM0 = (CNV_PULSE > CONV_WAIT) ? CNV_PULSE : CONV_WAIT;
    localparam int TMAX = (TM0 > 2 * SCK_HALF) ? TM0 : 2 * SCK_HALF;
    localparam int TW = $clog2(TMAX + 1);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] T_CNV  = TW'(CNV_PULSE - 1);
    localparam logic [TW-1:0] T_WAIT = TW'(CONV_WAIT - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(2 * SCK_HALF - 1);
    localparam logic [TW-1:0] T_HALF = TW'(SCK_HALF);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [PERIOD_WIDTH-1:0] P_MIN = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] P_ONE = PERIOD_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNV,
        S_WAIT,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [TW-1:0]           r_tcnt;
    logic [TW-1:0]           w_tcnt;
    logic [BW-1:0]           r_bit;
    logic [BW-1:0]           w_bit;
    logic [PERIOD_WIDTH-1:0] r_pcnt;
    logic [PERIOD_WIDTH-1:0] w_eff;
    logic [DATA_WIDTH-1:0]   r_sr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic                    r_cnv;
    logic                    r_sck;
    logic                    r_valid;
    logic                    r_ovr;
    logic                    r_miss;
    logic                    w_trig;
    logic                    w_sck;
    logic                    w_sample;
    logic                    w_ovr_set;
    logic                    w_miss_set;

    assign w_trig = enable && (r_pcnt == '0);
    assign w_eff  = (period < P_MIN) ? P_MIN : period;

    always_comb begin
        w_next = r_state;
        w_tcnt = r_tcnt;
        w_bit  = r_bit;
        unique case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_next = S_CNV;
                    w_tcnt = '0;
                end
            end
            S_CNV: begin
                if (r_tcnt == T_CNV) begin
                    w_next = S_WAIT;
                    w_tcnt = '0;
                end else begin
                    w_tcnt = r_tcnt + T_ONE;
                end
            end
            S_WAIT: begin
                if (r_tcnt == T_WAIT) begin
                    w_next = S_SHIFT;
                    w_tcnt = '0;
                    w_bit  = '0;
                end else begin
                    w_tcnt = r_tcnt + T_ONE;
                end
            end
            S_SHIFT: begin
                // one bit slot = SCK_HALF low cycles then SCK_HALF high cycles
                if (r_tcnt == T_BIT) begin
                    w_tcnt = '0;
                    if (r_bit == B_LAST) begin
                        w_next = S_DONE;
                    end else begin
                        w_bit = r_bit + B_ONE;
                    end
                end else begin
                    w_tcnt = r_tcnt + T_ONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_sck      = (w_next == S_SHIFT) && (w_tcnt >= T_HALF);
    assign w_sample   = w_sck && !r_sck;
    assign w_ovr_set  = (r_state == S_DONE) && r_valid && !m_ready;
    assign w_miss_set = w_trig && (r_state != S_IDLE);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            r_bit   <= '0;
            r_cnv   <= 1'b0;
            r_sck   <= 1'b0;
            r_sr    <= '0;
        end else begin
            r_state <= w_next;
            r_tcnt  <= w_tcnt;
            r_bit   <= w_bit;
            r_cnv   <= (w_next == S_CNV);
            r_sck   <= w_sck;
            if (w_sample) begin
                r_sr <= {r_sr[DATA_WIDTH-2:0], adc_dout};
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_pcnt  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            if (!enable) begin
                r_pcnt <= '0;
            end else if (w_trig) begin
                r_pcnt <= w_eff - P_ONE;
            end else begin
                r_pcnt <= r_pcnt - P_ONE;
            end
            if (r_state == S_DONE) begin
                r_data  <= r_sr;
                r_valid <= 1'b1;
            end else if (r_valid && m_ready) begin
                r_valid <= 1'b0;
            end
            r_ovr  <= w_ovr_set || (r_ovr && !clear_status);
            r_miss <= w_miss_set || (r_miss && !clear_status);
        end
    end

    assign adc_cnv        = r_cnv;
    assign adc_sck        = r_sck;
    assign m_data         = r_data;
    assign m_valid        = r_valid;
    assign busy           = (r_state != S_IDLE);
    assign overrun        = r_ovr;
    assign missed_trigger = r_miss;
endmodule
